// File: rtl/layer0_input_packer.sv
// rtl/layer0_input_packer.sv - quantises a 16-beat signed feature stream into the packed M0 vector for layer0.
// Optional frame/drop statistics counters are built when LAYER0_PACK_STATS_EN is defined.
module layer0_input_packer #(
  parameter int N_FEAT  = 16,
  parameter int IN_W    = 8,
  parameter int SHIFT   = 4,
  parameter int ZERO_PT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [4*N_FEAT-1:0]   M0,
  output logic                  err_len,
  input  logic                  err_clr
`ifdef LAYER0_PACK_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
  localparam logic signed [IN_W:0] ZP       = (IN_W+1)'(ZERO_PT);
  localparam logic signed [IN_W:0] CODE_MAX = (IN_W+1)'(15);

  typedef enum logic {ST_FILL = 1'b0, ST_PEND = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_FEAT-1:0]   fill_q, fill_d;
  logic [4*N_FEAT-1:0]   m0_q, m0_d;
  logic                  m_valid_q, m_valid_d;
  logic                  err_q, err_d;

  logic signed [IN_W:0]  q_ext, q_sh, q_t;
  logic [3:0]            code;
  logic [4*N_FEAT-1:0]   fill_merged;
  logic                  beat_acc, at_last, frame_done, frame_drop;
  logic                  slot_free, transfer, xfer_from_pend;

  // Quantiser: shift and offset at IN_W+1 bits so the zero-point add cannot wrap.
  always_comb begin
    q_ext = {s_data[IN_W-1], s_data};
    q_sh  = q_ext >>> SHIFT;
    q_t   = q_sh + ZP;
    if (q_t < 0) begin
      code = 4'd0;
    end else if (q_t > CODE_MAX) begin
      code = 4'd15;
    end else begin
      code = q_t[3:0];
    end
  end

  always_comb begin
    fill_merged = fill_q;
    fill_merged[{idx_q, 2'b00} +: 4] = code;
  end

  assign beat_acc   = s_valid & s_ready;
  assign at_last    = (idx_q == LAST_IDX);
  assign frame_done = beat_acc & at_last & s_last;
  // Either an early s_last or a missing one at the final slot drops the frame.
  assign frame_drop = beat_acc & (at_last ^ s_last);
  assign slot_free  = ~m_valid_q | m_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (frame_done && !slot_free) state_d = ST_PEND;
      ST_PEND: if (slot_free)                state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    s_ready        = 1'b0;
    transfer       = 1'b0;
    xfer_from_pend = 1'b0;
    case (state_q)
      ST_FILL: begin
        s_ready  = 1'b1;
        transfer = frame_done & slot_free;
      end
      ST_PEND: begin
        transfer       = slot_free;
        xfer_from_pend = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if (frame_done || frame_drop) begin
      idx_d = '0;
    end else if (beat_acc) begin
      idx_d = idx_q + 1'b1;
    end
  end

  assign fill_d = beat_acc ? fill_merged : fill_q;

  // In FILL the final code is still in flight, so M0 takes the merged view.
  always_comb begin
    m0_d      = m0_q;
    m_valid_d = m_valid_q;
    if (transfer) begin
      m0_d      = xfer_from_pend ? fill_q : fill_merged;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_comb begin
    err_d = err_q;
    if (frame_drop) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      fill_q    <= '0;
      m0_q      <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      fill_q    <= fill_d;
      m0_q      <= m0_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
    end
  end

  assign M0      = m0_q;
  assign m_valid = m_valid_q;
  assign err_len = err_q;

`ifdef LAYER0_PACK_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating counters; deliberately untouched by err_clr.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (transfer && frame_cnt_q != 16'hFFFF) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (frame_drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_layer0_input_packer.sv
// tb/tb_layer0_input_packer.sv - scoreboard bench for layer0_input_packer.
module tb_layer0_input_packer;

  localparam logic [63:0] RAMP   = 64'h7654_3210_FEDC_BA98;
  localparam logic [63:0] ALL_0  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] ALL_8  = 64'h8888_8888_8888_8888;
  localparam logic [63:0] ALL_F  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ALL_7  = 64'h7777_7777_7777_7777;
  localparam logic [63:0] ALL_A  = 64'hAAAA_AAAA_AAAA_AAAA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] M0;
  logic        err_len;
  logic        err_clr;
`ifdef LAYER0_PACK_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
`endif

  logic [63:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  layer0_input_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .M0       (M0),
    .err_len  (err_len),
    .err_clr  (err_clr)
`ifdef LAYER0_PACK_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL m0_unexpected: got %h with no frame expected", M0);
      end else begin
        check("m0_scoreboard", M0, exp_q.pop_front());
      end
    end
  end

  task automatic beat(input logic [7:0] d, input logic last);
    int waitc = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && waitc < 64) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!s_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL s_ready_timeout: s_ready stayed 0 for %0d cycles", waitc);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_const(input logic [7:0] val, input int n, input int last_at);
    for (int i = 0; i < n; i++) beat(val, i == last_at);
  endtask

  task automatic send_ramp();
    for (int i = 0; i < 16; i++) beat(8'(i * 16), i == 15);
  endtask

  initial begin
    int w;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    err_clr = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m0", M0, ALL_0);
    check("rst_err_len", err_len, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp, then saturation frames
    exp_q.push_back(RAMP);
    send_ramp();
    check("ramp_latency_valid", m_valid, 1);
    check("ramp_m0", M0, RAMP);
    exp_q.push_back(ALL_0);
    send_const(8'h80, 16, 15);
    exp_q.push_back(ALL_F);
    send_const(8'h7F, 16, 15);
    @(posedge clk); #1;

    // Backpressure: A held, B pending
    m_ready = 1'b0;
    exp_q.push_back(ALL_8);
    send_const(8'h00, 16, 15);
    check("bp_a_valid", m_valid, 1);
    check("bp_a_m0", M0, ALL_8);
    exp_q.push_back(ALL_F);
    send_const(8'h7F, 16, 15);
    check("pend_s_ready", s_ready, 0);
    check("pend_hold_a", M0, ALL_8);
    repeat (3) @(posedge clk); #1;
    check("pend_hold_a_later", M0, ALL_8);
    check("pend_s_ready_later", s_ready, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("swap_valid", m_valid, 1);
    check("swap_m0_b", M0, ALL_F);
    check("swap_s_ready", s_ready, 1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", m_valid, 0);
    check("drain_hold_m0", M0, ALL_F);

    // Early s_last at idx 5
    send_const(8'h10, 6, 5);
    check("early_err", err_len, 1);
    check("early_no_valid", m_valid, 0);
    exp_q.push_back(ALL_7);
    send_const(8'hF0, 16, 15);
    err_clr = 1'b1;
    beat(8'h00, 1'b1);
    err_clr = 1'b0;
    check("err_set_wins", err_len, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("err_cleared", err_len, 0);

    // Missing s_last at idx 15
    send_const(8'h00, 16, -1);
    check("missing_err", err_len, 1);
    check("missing_no_valid", m_valid, 0);
    exp_q.push_back(ALL_A);
    send_const(8'h20, 16, 15);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;

    // Reset mid-frame at idx 9
    send_const(8'h30, 9, -1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_m_valid", m_valid, 0);
    check("rst_mid_s_ready", s_ready, 1);
    check("rst_mid_m0", M0, ALL_0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(ALL_F);
    send_const(8'h7F, 16, 15);
    @(posedge clk); #1;

    // Reset while in PEND
    m_ready = 1'b0;
    send_const(8'h00, 16, 15);
    send_const(8'h7F, 16, 15);
    check("pend2_s_ready", s_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rst_pend_m_valid", m_valid, 0);
    check("rst_pend_s_ready", s_ready, 1);
    check("rst_pend_m0", M0, ALL_0);
    check("rst_pend_err", err_len, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;

    // Three good frames and two dropped since the last reset
    exp_q.push_back(RAMP);
    send_ramp();
    send_const(8'h10, 3, 2);
    exp_q.push_back(ALL_7);
    send_const(8'hF0, 16, 15);
    send_const(8'h00, 16, -1);
    exp_q.push_back(ALL_A);
    send_const(8'h20, 16, 15);

    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("scoreboard_empty", 64'(exp_q.size()), 0);
`ifdef LAYER0_PACK_STATS_EN
    check("frame_cnt", frame_cnt, 3);
    check("drop_cnt", drop_cnt, 2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
